// File: rtl/dm_load_unit_if.sv
// Load-path bundle: M-stage load request/result plus the data-memory read port.
// The load unit takes the master side; the pipeline and memory take the slave side.
interface dm_load_unit_if;
    localparam int unsigned XLEN = 32;

    logic            ld_valid;
    logic [2:0]      ld_type;
    logic [XLEN-1:0] ld_addr;
    logic            ld_stall;
    logic            ld_done;
    logic [XLEN-1:0] ld_data;
    logic            ld_err;
    logic            ld_exc;

    logic            m_data_rd_req;
    logic [XLEN-1:0] m_data_addr;
    logic            m_data_rvalid;
    logic [XLEN-1:0] m_data_rdata;

    modport master (
        input  ld_valid, ld_type, ld_addr, m_data_rvalid, m_data_rdata,
        output ld_stall, ld_done, ld_data, ld_err, ld_exc, m_data_rd_req, m_data_addr
    );

    modport slave (
        output ld_valid, ld_type, ld_addr, m_data_rvalid, m_data_rdata,
        input  ld_stall, ld_done, ld_data, ld_err, ld_exc, m_data_rd_req, m_data_addr
    );
endinterface

// File: rtl/dm_load_unit.sv
// Memory-stage load unit: alignment check, word read over a strobe/valid handshake
// with timeout, then byte/halfword extraction with sign or zero extension.
module dm_load_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    dm_load_unit_if.master bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      type_q, type_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            req_q, req_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            exc_q, exc_d;

    logic            legal_c;
    logic [XLEN-1:0] ext_c;
    logic [15:0]     half_c;
    logic [XLEN-1:0] byte_sh_c;
    logic [7:0]      byte_c;

    // Alignment / type legality of the incoming request
    always_comb begin
        legal_c = 1'b0;
        case (bus.ld_type)
            LD_LW:          legal_c = (bus.ld_addr[1:0] == 2'b00);
            LD_LH, LD_LHU:  legal_c = ~bus.ld_addr[0];
            LD_LB, LD_LBU:  legal_c = 1'b1;
            default:        legal_c = 1'b0;
        endcase
    end

    // Lane select and extension using the latched type and low address bits
    always_comb begin
        half_c    = off_q[1] ? bus.m_data_rdata[31:16] : bus.m_data_rdata[15:0];
        byte_sh_c = bus.m_data_rdata >> {off_q, 3'b000};
        byte_c    = byte_sh_c[7:0];
        ext_c     = bus.m_data_rdata;
        case (type_q)
            LD_LH:   ext_c = {{16{half_c[15]}}, half_c};
            LD_LHU:  ext_c = {16'h0000, half_c};
            LD_LB:   ext_c = {{24{byte_c[7]}}, byte_c};
            LD_LBU:  ext_c = {24'h000000, byte_c};
            default: ext_c = bus.m_data_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            type_q  <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            exc_q   <= exc_d;
        end
    end

    // Pulse outputs are registered on the transition into the state they belong to
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        off_d   = off_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        req_d   = 1'b0;
        done_d  = 1'b0;
        exc_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ld_valid) begin
                    if (legal_c) begin
                        type_d  = bus.ld_type;
                        off_d   = bus.ld_addr[1:0];
                        addr_d  = {bus.ld_addr[31:2], 2'b00};
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        exc_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.m_data_rvalid) begin
                    data_d  = ext_c;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stall rises in the accepting cycle so the M stage holds the load in place
    assign bus.ld_stall      = (state_q == S_REQ) || (state_q == S_WAIT) ||
                               ((state_q == S_IDLE) && bus.ld_valid && legal_c);
    assign bus.m_data_rd_req = req_q;
    assign bus.m_data_addr   = addr_q;
    assign bus.ld_done       = done_q;
    assign bus.ld_data       = data_q;
    assign bus.ld_err        = err_q;
    assign bus.ld_exc        = exc_q;
endmodule
